// File: rtl/n101_queue_param.sv
// Parametrised ready/valid FIFO: power-of-two depth, synchronous flush,
// almost-full/empty flags, high-water mark and optional empty-queue bypass.
module n101_queue_param #(
  parameter int DW         = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_THR  = DEPTH - 1,
  parameter int AEMPTY_THR = 1,
  parameter int FLOW       = 0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  output logic          enq_ready,
  input  logic          enq_valid,
  input  logic [DW-1:0] enq_bits,
  input  logic          deq_ready,
  output logic          deq_valid,
  output logic [DW-1:0] deq_bits,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          almost_empty,
  input  logic          hwm_clr,
  output logic [AW:0]   hwm
);

  localparam logic [AW:0] AF_THR = (AW+1)'(AFULL_THR);
  localparam logic [AW:0] AE_THR = (AW+1)'(AEMPTY_THR);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          maybe_full_q, maybe_full_d;
  logic [AW:0]   hwm_q, hwm_d, count_d;
  logic          ptr_match, empty, full, bypass;
  logic          do_enq, do_deq, wr_en, rd_en;

  always_comb begin
    ptr_match = (wptr_q == rptr_q);
    empty     = ptr_match & ~maybe_full_q;
    full      = ptr_match & maybe_full_q;
    bypass    = (FLOW != 0) & empty & ~flush;

    enq_ready = ~full & ~flush;
    deq_valid = ~flush & (~empty | (bypass & enq_valid));
    deq_bits  = bypass ? enq_bits : mem_q[rptr_q];

    do_enq = enq_valid & enq_ready;
    do_deq = deq_valid & deq_ready;
    // A bypassed transfer touches neither storage nor pointers.
    wr_en  = do_enq & ~(bypass & do_deq);
    rd_en  = do_deq & ~bypass;

    wptr_d       = flush ? '0 : wptr_q + AW'(wr_en);
    rptr_d       = flush ? '0 : rptr_q + AW'(rd_en);
    maybe_full_d = flush ? 1'b0 : ((wr_en != rd_en) ? wr_en : maybe_full_q);

    count   = {maybe_full_q & ptr_match, wptr_q - rptr_q};
    count_d = {maybe_full_d & (wptr_d == rptr_d), wptr_d - rptr_d};

    almost_full  = (count >= AF_THR);
    almost_empty = (count <= AE_THR);

    // Tracks post-edge occupancy so the mark includes this cycle's enqueue.
    if (hwm_clr)              hwm_d = count_d;
    else if (count_d > hwm_q) hwm_d = count_d;
    else                      hwm_d = hwm_q;
  end

  assign hwm = hwm_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      maybe_full_q <= 1'b0;
      hwm_q        <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      maybe_full_q <= maybe_full_d;
      hwm_q        <= hwm_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wptr_q] <= enq_bits;
  end

endmodule

// File: tb/tb_n101_queue_param.sv
// Drives one shared stimulus stream into a FLOW=0 and a FLOW=1 queue, each
// checked every cycle against its own queue-based scoreboard.
module tb_n101_queue_param;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       flush = 1'b0;
  logic       enq_valid = 1'b0;
  logic [7:0] enq_bits = '0;
  logic       deq_ready = 1'b0;
  logic       hwm_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h @%0t", name, inst, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic       enq_ready, deq_valid, almost_full, almost_empty;
    logic [7:0] deq_bits;
    logic [3:0] count, hwm;
    logic [7:0] sb [$];
    int         hwm_m = 0;

    n101_queue_param #(.DW(8), .DEPTH(DEPTH), .FLOW(g)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .enq_ready(enq_ready), .enq_valid(enq_valid), .enq_bits(enq_bits),
      .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_bits(deq_bits),
      .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
      .hwm_clr(hwm_clr), .hwm(hwm)
    );

    // Reference model: contents as a plain queue, updated on each edge.
    always @(posedge clock) begin
      if (reset_n) begin
        int  n;
        bit  er, dv, en, de;
        n  = sb.size();
        er = (n < DEPTH) && !flush;
        dv = !flush && (n > 0 || (g == 1 && enq_valid));
        en = enq_valid && er;
        de = dv && deq_ready;
        if (flush) sb.delete();
        else if (!(n == 0 && en && de)) begin
          if (de) void'(sb.pop_front());
          if (en) sb.push_back(enq_bits);
        end
        if (hwm_clr) hwm_m = sb.size();
        else if (sb.size() > hwm_m) hwm_m = sb.size();
      end
    end

    // Monitor: compare every visible output against the model mid-cycle.
    always @(negedge clock) begin
      if (reset_n) begin
        int n;
        bit dv;
        n  = sb.size();
        dv = !flush && (n > 0 || (g == 1 && enq_valid));
        chk("count", g, int'(count), n);
        chk("enq_ready", g, int'(enq_ready), int'((n < DEPTH) && !flush));
        chk("deq_valid", g, int'(deq_valid), int'(dv));
        chk("almost_full", g, int'(almost_full), int'(n >= DEPTH - 1));
        chk("almost_empty", g, int'(almost_empty), int'(n <= 1));
        chk("hwm", g, int'(hwm), hwm_m);
        if (dv && deq_ready)
          chk("deq_bits", g, int'(deq_bits), (n > 0) ? int'(sb[0]) : int'(enq_bits));
      end
    end

    // Asynchronous reset takes effect without any clock edge.
    always @(negedge reset_n) begin
      sb.delete();
      hwm_m = 0;
      #1;
      chk("rst_count", g, int'(count), 0);
      chk("rst_enq_ready", g, int'(enq_ready), 1);
      chk("rst_deq_valid", g, int'(deq_valid), (g == 1) ? int'(enq_valid) : 0);
      chk("rst_almost_full", g, int'(almost_full), 0);
      chk("rst_almost_empty", g, int'(almost_empty), 1);
      chk("rst_hwm", g, int'(hwm), 0);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input bit ev, input logic [7:0] b, input bit dr);
    enq_valid = ev;
    enq_bits  = b;
    deq_ready = dr;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // Fill to full, then full with both handshakes offered.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 0);
      cyc();
    end
    drive(0, 8'h00, 0);
    cyc();
    drive(1, 8'h99, 1);
    cyc();
    drive(0, 8'h00, 0);
    cyc();
    drive(0, 8'h00, 1);
    cyc(9);

    // Steady-state streaming across pointer wrap.
    hwm_clr = 1'b1;
    drive(0, 8'h00, 0);
    cyc();
    hwm_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h10 + i), 0);
      cyc();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'(8'h20 + i), 1);
      cyc();
    end
    drive(0, 8'h00, 1);
    cyc(6);

    // Flush at count 6 with both handshakes offered, then clear the mark.
    hwm_clr = 1'b1;
    drive(0, 8'h00, 0);
    cyc();
    hwm_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(8'h40 + i), 0);
      cyc();
    end
    flush = 1'b1;
    drive(1, 8'h77, 1);
    cyc();
    flush = 1'b0;
    drive(0, 8'h00, 0);
    cyc();
    hwm_clr = 1'b1;
    cyc();
    hwm_clr = 1'b0;
    cyc();

    // Empty-queue transfer: bypass in the FLOW instance, enqueue otherwise.
    drive(1, 8'hA5, 1);
    cyc();
    drive(1, 8'h5A, 0);
    cyc();
    drive(0, 8'h00, 1);
    cyc(3);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 31) == 0);
      hwm_clr = ($urandom_range(0, 31) == 0);
      cyc();
    end
    flush = 1'b0;
    hwm_clr = 1'b0;

    // Reset mid-burst at count 4, between clock edges.
    drive(0, 8'h00, 1);
    cyc(10);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'hC0 + i), 0);
      cyc();
    end
    drive(1, 8'hCC, 0);
    #2 reset_n = 1'b0;
    cyc(2);
    drive(0, 8'h00, 0);
    reset_n = 1'b1;
    cyc(2);
    drive(1, 8'hE1, 1);
    cyc(3);
    drive(0, 8'h00, 1);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
